// File: rtl/systolic_tile_feeder_pkg.sv
// Shared definitions for the systolic tile feeder and the array it drives:
// state encoding, default geometry and flat tile element indexing.
package systolic_tile_feeder_pkg;

  localparam int DEFAULT_N      = 4;
  localparam int DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_t;

  // Flat element index of A[i][k] within a row-major N x N tile.
  function automatic int elem_a(input int i, input int k, input int n);
    return i * n + k;
  endfunction

  // Flat element index of B[k][j] within a row-major N x N tile.
  function automatic int elem_b(input int k, input int j, input int n);
    return k * n + j;
  endfunction

endpackage

// File: rtl/systolic_tile_feeder_skew.sv
// One edge lane of the feeder: picks candidate (t - LANE) out of N operands,
// or zero while the skewed lane is outside its feed window.
module skew_lane_select
  import systolic_tile_feeder_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int T_W    = 3,
  parameter int LANE   = 0
) (
  input  logic [T_W-1:0]      t,
  input  logic [N*DATA_W-1:0] cand,
  output logic [DATA_W-1:0]   operand
);

  always_comb begin
    operand = '0;
    for (int k = 0; k < N; k++) begin
      if (t == T_W'(LANE + k)) begin
        operand = cand[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/systolic_tile_feeder.sv
// N x N operand feeder: accepts one A/B tile pair, streams it diagonally skewed
// into the array's west/north edges, then drains and signals block completion.
module systolic_tile_feeder
  import systolic_tile_feeder_pkg::*;
#(
  parameter int N            = DEFAULT_N,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tile_valid,
  output logic                    tile_ready,
  input  logic                    tile_last,
  input  logic [N*N*DATA_W-1:0]   tile_a,
  input  logic [N*N*DATA_W-1:0]   tile_b,
  output logic [N*DATA_W-1:0]     west_data,
  output logic [N*DATA_W-1:0]     north_data,
  output logic                    feed_valid,
  output logic                    acc_clear,
  output logic                    busy,
  output logic                    done
);

  localparam int TILE_W = N * N * DATA_W;
  localparam int EDGE_W = N * DATA_W;
  localparam int T_W    = $clog2(2 * N - 1);
  localparam int DC_W   = $clog2(DRAIN_CYCLES + 1);

  localparam logic [T_W-1:0]  T_LAST     = T_W'(2 * N - 2);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);

  feeder_state_t state_reg, state_next;
  logic [T_W-1:0]    t_reg, t_next;
  logic [DC_W-1:0]   drain_reg, drain_next;
  logic [TILE_W-1:0] buf_a_reg, buf_a_next;
  logic [TILE_W-1:0] buf_b_reg, buf_b_next;
  logic              last_reg, last_next;
  logic              block_open_reg, block_open_next;
  logic              acc_clear_next;
  logic              feed_next;

  logic              tile_ready_reg;
  logic [EDGE_W-1:0] west_reg, north_reg;
  logic              feed_valid_reg, acc_clear_reg, busy_reg, done_reg;

  logic [EDGE_W-1:0] west_cand  [N];
  logic [EDGE_W-1:0] north_cand [N];
  logic [EDGE_W-1:0] west_sel, north_sel;

  always_comb begin
    state_next      = state_reg;
    t_next          = t_reg;
    drain_next      = drain_reg;
    buf_a_next      = buf_a_reg;
    buf_b_next      = buf_b_reg;
    last_next       = last_reg;
    block_open_next = block_open_reg;
    acc_clear_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (tile_valid && tile_ready_reg) begin
          buf_a_next      = tile_a;
          buf_b_next      = tile_b;
          last_next       = tile_last;
          t_next          = '0;
          state_next      = ST_FEED;
          // Only the first k-tile of an output block clears the accumulators.
          acc_clear_next  = !block_open_reg;
          block_open_next = 1'b1;
        end
      end
      ST_FEED: begin
        if (t_reg == T_LAST) begin
          t_next     = '0;
          drain_next = '0;
          state_next = ST_DRAIN;
        end else begin
          t_next = t_reg + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          drain_next = '0;
          state_next = last_reg ? ST_DONE : ST_IDLE;
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      ST_DONE: begin
        block_open_next = 1'b0;
        state_next      = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    feed_next = (state_next == ST_FEED);
  end

  // Lanes select from the next-cycle buffer and count so the edge registers
  // already hold beat t=0 in the first FEED cycle.
  genvar gi, gk;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      for (gk = 0; gk < N; gk++) begin : g_elem
        assign west_cand[gi][gk*DATA_W +: DATA_W]  = buf_a_next[elem_a(gi, gk, N)*DATA_W +: DATA_W];
        assign north_cand[gi][gk*DATA_W +: DATA_W] = buf_b_next[elem_b(gk, gi, N)*DATA_W +: DATA_W];
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_lane
      skew_lane_select #(
        .N      (N),
        .DATA_W (DATA_W),
        .T_W    (T_W),
        .LANE   (gi)
      ) u_west_lane (
        .t       (t_next),
        .cand    (west_cand[gi]),
        .operand (west_sel[gi*DATA_W +: DATA_W])
      );

      skew_lane_select #(
        .N      (N),
        .DATA_W (DATA_W),
        .T_W    (T_W),
        .LANE   (gi)
      ) u_north_lane (
        .t       (t_next),
        .cand    (north_cand[gi]),
        .operand (north_sel[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      t_reg          <= '0;
      drain_reg      <= '0;
      buf_a_reg      <= '0;
      buf_b_reg      <= '0;
      last_reg       <= 1'b0;
      block_open_reg <= 1'b0;
      tile_ready_reg <= 1'b1;
      west_reg       <= '0;
      north_reg      <= '0;
      feed_valid_reg <= 1'b0;
      acc_clear_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      t_reg          <= t_next;
      drain_reg      <= drain_next;
      buf_a_reg      <= buf_a_next;
      buf_b_reg      <= buf_b_next;
      last_reg       <= last_next;
      block_open_reg <= block_open_next;
      tile_ready_reg <= (state_next == ST_IDLE);
      west_reg       <= feed_next ? west_sel  : '0;
      north_reg      <= feed_next ? north_sel : '0;
      feed_valid_reg <= feed_next;
      acc_clear_reg  <= acc_clear_next;
      busy_reg       <= (state_next != ST_IDLE);
      done_reg       <= (state_next == ST_DONE);
    end
  end

  assign tile_ready = tile_ready_reg;
  assign west_data  = west_reg;
  assign north_data = north_reg;
  assign feed_valid = feed_valid_reg;
  assign acc_clear  = acc_clear_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule
